// File: rtl/mux_2x1_stream_pkg.sv
// Shared types and helpers for the 2:1 stream multiplexer.
package mux_2x1_stream_pkg;

  // The output holding register is either empty or holds one unconsumed beat.
  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } hold_state_e;

  // Converts a source index (0 = in1, 1 = in2) to a one-hot grant vector.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    logic [1:0] v;
    v      = 2'b00;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_2x1_stream_rr_arb_2.sv
// Two-requester round-robin arbiter with a forced-selection override.
// The grant is purely combinational. The caller owns the last_grant history.
module mux_2x1_stream_rr_arb_2
  import mux_2x1_stream_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  input  logic       i_force_en,
  input  logic       i_select,
  output logic [1:0] o_gnt
);

  // Forced source wins unconditionally; otherwise alternate on ties.
  always_comb begin
    o_gnt = 2'b00;
    if (i_force_en) begin
      // A forced grant is given even without a request. The caller qualifies it with valid.
      o_gnt = idx_to_onehot(i_select);
    end else begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = idx_to_onehot(~i_last_grant);
        default: o_gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mux_2x1_stream.sv
// Registered 2:1 stream multiplexer: merges two valid/ready sources into one
// output register. Arbitration is round-robin unless force_en pins the source.
module mux_2x1_stream
  import mux_2x1_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_valid,
  output logic             in2_ready,
  input  logic             select,
  input  logic             force_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_src,
  input  logic             out_ready
);

  localparam logic SRC1 = 1'b0;
  localparam logic SRC2 = 1'b1;

  hold_state_e      r_state;
  hold_state_e      w_state_next;
  logic [WIDTH-1:0] r_data;
  logic             r_src;
  logic             r_last_grant;

  logic [1:0]       w_gnt;
  logic             w_accept;
  logic             w_gnt_idx;
  logic             w_gnt_valid;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_xfer;

  mux_2x1_stream_rr_arb_2 u_arb (
    .i_req        ({in2_valid, in1_valid}),
    .i_last_grant (r_last_grant),
    .i_force_en   (force_en),
    .i_select     (select),
    .o_gnt        (w_gnt)
  );

  // Transfer qualification. Reset blocks acceptance so nothing is handshaken while reset is high.
  always_comb begin
    w_accept    = (r_state == StEmpty) | out_ready;
    w_gnt_idx   = w_gnt[SRC2];
    w_gnt_valid = (w_gnt[SRC1] & in1_valid) | (w_gnt[SRC2] & in2_valid);
    w_gnt_data  = w_gnt[SRC2] ? in2_data : in1_data;
    w_xfer      = w_accept & w_gnt_valid & ~reset;
    in1_ready   = in1_valid & w_gnt[SRC1] & w_accept & ~reset;
    in2_ready   = in2_valid & w_gnt[SRC2] & w_accept & ~reset;
  end

  // Holding-register next state: fill on transfer, empty on drain without refill.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StEmpty: if (w_xfer) w_state_next = StFull;
      StFull:  if (out_ready && !w_xfer) w_state_next = StEmpty;
      default: w_state_next = StEmpty;
    endcase
  end

  // State register. A beat held at reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Payload, source tag and arbitration history, all updated only on a real transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data       <= '0;
      r_src        <= SRC1;
      r_last_grant <= SRC2;  // in1 wins the first tie after reset
    end else if (w_xfer) begin
      r_data       <= w_gnt_data;
      r_src        <= w_gnt_idx;
      r_last_grant <= w_gnt_idx;
    end
  end

  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_valid = (r_state == StFull);

endmodule

// File: tb/tb_mux_2x1_stream.sv
// Directed bench for mux_2x1_stream. Inputs change 1 ns after a rising edge.
// Ready outputs are checked 1 ns later. Registered outputs are checked 1 ns after the next edge.
module tb_mux_2x1_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in1_data, in2_data, out_data;
  logic       in1_valid, in2_valid, in1_ready, in2_ready;
  logic       select, force_en, out_valid, out_src, out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_2x1_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in2_data  (in2_data),
    .in2_valid (in2_valid),
    .in2_ready (in2_ready),
    .select    (select),
    .force_en  (force_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the registered output triple.
  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
    chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".src"}, {7'd0, out_src}, {7'd0, s});
  endtask

  task automatic chk_rdy(input string tag, input logic r1, input logic r2);
    chk({tag, ".in1_ready"}, {7'd0, in1_ready}, {7'd0, r1});
    chk({tag, ".in2_ready"}, {7'd0, in2_ready}, {7'd0, r2});
  endtask

  logic [7:0] alt_data [4];
  logic       alt_src  [4];
  logic [7:0] seq_data [3];

  initial begin
    alt_data = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};
    alt_src  = '{1'b0, 1'b1, 1'b0, 1'b1};
    seq_data = '{8'h01, 8'h02, 8'h03};

    // Reset held for 2 cycles with both sources valid.
    reset = 1'b1; in1_data = 8'hA1; in2_data = 8'hB2; in1_valid = 1'b1; in2_valid = 1'b1;
    select = 1'b0; force_en = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    chk_out("reset", 1'b0, 8'h00, 1'b0);
    chk_rdy("reset", 1'b0, 1'b0);

    // Alternation: the first tie goes to in1, then strict alternation, one beat per cycle.
    reset = 1'b0;
    #1;
    chk_rdy("first_tie", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("alt%0d", i), 1'b1, alt_data[i], alt_src[i]);
    end

    // Load 5C from in1 only, then stall the sink for 3 cycles.
    in1_data = 8'h5C; in2_valid = 1'b0;
    tick();
    chk_out("load5c", 1'b1, 8'h5C, 1'b0);
    in1_valid = 1'b0; in2_valid = 1'b1; in2_data = 8'hB2; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_rdy($sformatf("stall%0d", i), 1'b0, 1'b0);
      tick();
      chk_out($sformatf("stall%0d", i), 1'b1, 8'h5C, 1'b0);
    end
    // Release: 5C is drained and B2 is loaded on the same edge.
    out_ready = 1'b1;
    #1;
    chk_rdy("release", 1'b0, 1'b1);
    tick();
    chk_out("release", 1'b1, 8'hB2, 1'b1);

    // Force in2 with both sources valid.
    force_en = 1'b1; select = 1'b1; in1_valid = 1'b1; in1_data = 8'hA1; in2_data = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_rdy($sformatf("force%0d", i), 1'b0, 1'b1);
      tick();
      chk_out($sformatf("force%0d", i), 1'b1, 8'hC3, 1'b1);
    end
    // Drain without refill: valid drops, payload and source hold.
    force_en = 1'b0; select = 1'b0; in1_valid = 1'b0; in2_valid = 1'b0;
    tick();
    chk_out("drain", 1'b0, 8'hC3, 1'b1);

    // Single source in2: three beats in order.
    in2_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in2_data = seq_data[i];
      #1;
      chk_rdy($sformatf("single%0d", i), 1'b0, 1'b1);
      tick();
      chk_out($sformatf("single%0d", i), 1'b1, seq_data[i], 1'b1);
    end
    in2_valid = 1'b0;
    tick();
    chk_out("single_drain", 1'b0, 8'h03, 1'b1);
    // Last grant was in2, so the next tie goes to in1.
    in1_valid = 1'b1; in2_valid = 1'b1; in1_data = 8'h11; in2_data = 8'h22;
    #1;
    chk_rdy("tie_after_single", 1'b1, 1'b0);
    tick();
    chk_out("tie_after_single", 1'b1, 8'h11, 1'b0);

    // Mid-operation reset while holding EE with the sink stalled.
    in2_valid = 1'b0; in1_data = 8'hEE;
    tick();
    chk_out("load_ee", 1'b1, 8'hEE, 1'b0);
    out_ready = 1'b0; reset = 1'b1;
    #1;
    chk_rdy("mid_reset", 1'b0, 1'b0);
    tick();
    chk_out("mid_reset", 1'b0, 8'h00, 1'b0);
    reset = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk_out("post_reset", 1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
